// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory between two cache ports.
// A grant is held until the memory acknowledges, followed by one release cycle.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t state, state_n;
  logic   owner, owner_n;
  logic   prio, prio_n;

  // State, owner and tie-break priority registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      prio  <= prio_n;
    end
  end

  // Next-state: arbitrate in IDLE, wait for memory ack in BUSY, one idle gap in RELEASE.
  always_comb begin
    state_n = state;
    owner_n = owner;
    prio_n  = prio;
    case (state)
      IDLE: begin
        if (p0_enable_i && p1_enable_i) begin
          owner_n = prio;
          state_n = BUSY;
        end else if (p0_enable_i || p1_enable_i) begin
          owner_n = p1_enable_i;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          prio_n  = ~owner;
          state_n = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: memory side muxed from the owner only while BUSY; acks steered to the owner.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    grant_o      = 2'b00;
    p0_ack_o     = 1'b0;
    p1_ack_o     = 1'b0;
    p0_data_o    = mem_data_i;
    p1_data_o    = mem_data_i;
    if (state == BUSY) begin
      mem_enable_o = 1'b1;
      mem_write_o  = owner ? p1_write_i : p0_write_i;
      mem_addr_o   = owner ? p1_addr_i  : p0_addr_i;
      mem_data_o   = owner ? p1_data_i  : p0_data_i;
      grant_o      = owner ? 2'b10 : 2'b01;
      p0_ack_o     = mem_ack_i & ~owner;
      p1_ack_o     = mem_ack_i & owner;
    end
  end

endmodule
